// File: rtl/reqrsp_pkg.sv
// Request/response protocol definitions shared across the cluster.
// Only the atomic memory operation opcodes are needed by the TCDM banks.
package reqrsp_pkg;

    typedef enum logic [3:0] {
        AMONone = 4'h0,
        AMOSwap = 4'h1,
        AMOAdd  = 4'h2,
        AMOAnd  = 4'h3,
        AMOOr   = 4'h4,
        AMOXor  = 4'h5,
        AMOMax  = 4'h6,
        AMOMaxu = 4'h7,
        AMOMin  = 4'h8,
        AMOMinu = 4'h9,
        AMOLR   = 4'hA,
        AMOSC   = 4'hB
    } amo_op_e;

endpackage

// File: rtl/snitch_tcdm_pkg.sv
// Widths and bank-side request/response structs of the TCDM interconnect,
// plus the upper bound on the bank response latency.
package snitch_tcdm_pkg;

    localparam int unsigned TcdmAddrWidth = 10;
    localparam int unsigned TcdmDataWidth = 64;
    localparam int unsigned TcdmStrbWidth = TcdmDataWidth / 8;
    localparam int unsigned TcdmUserWidth = 1;
    localparam int unsigned MaxMemLatency = 4;

    typedef struct packed {
        logic [TcdmAddrWidth-1:0] addr;
        logic                     write;
        reqrsp_pkg::amo_op_e      amo;
        logic [TcdmDataWidth-1:0] data;
        logic [TcdmStrbWidth-1:0] strb;
        logic [TcdmUserWidth-1:0] user;
    } mem_req_chan_t;

    typedef struct packed {
        mem_req_chan_t q;
        logic          q_valid;
    } mem_req_t;

    typedef struct packed {
        logic [TcdmDataWidth-1:0] data;
    } mem_rsp_chan_t;

    typedef struct packed {
        mem_rsp_chan_t p;
    } mem_rsp_t;

endpackage

// File: rtl/snitch_tcdm_mem_delay.sv
// Valid+data shift register adding Depth cycles to the bank response path.
// Depth 0 is a plain wire; the clear is synchronous with rst_ni.
module snitch_tcdm_mem_delay #(
    parameter int          Depth = 0,
    parameter int unsigned Width = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             i_valid,
    input  logic [Width-1:0] i_data,
    output logic             o_valid,
    output logic [Width-1:0] o_data
);

    if (Depth == 0) begin : gen_bypass
        logic w_unused_clk_rst;
        assign w_unused_clk_rst = clk_i ^ rst_ni;
        assign o_valid          = i_valid;
        assign o_data           = i_data;
    end else begin : gen_pipe
        logic [Depth-1:0]            r_valid;
        logic [Depth-1:0][Width-1:0] r_data;

        // Clearing the data stages too keeps idle-cycle data at zero everywhere.
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                r_valid <= '0;
                r_data  <= '0;
            end else begin
                r_valid[0] <= i_valid;
                r_data[0]  <= i_data;
                for (int i = 1; i < Depth; i++) begin
                    r_valid[i] <= r_valid[i-1];
                    r_data[i]  <= r_data[i-1];
                end
            end
        end

        assign o_valid = r_valid[Depth-1];
        assign o_data  = r_data[Depth-1];
    end

endmodule

// File: rtl/snitch_tcdm_mem_bank.sv
// Fixed-latency TCDM bank: read, strobed write and AMO on a local word array,
// one request per cycle, response after MemoryResponseLatency cycles.
module snitch_tcdm_mem_bank
    import reqrsp_pkg::*;
    import snitch_tcdm_pkg::MaxMemLatency;
#(
    parameter int unsigned MemAddrWidth          = snitch_tcdm_pkg::TcdmAddrWidth,
    parameter int unsigned DataWidth             = snitch_tcdm_pkg::TcdmDataWidth,
    parameter int unsigned MemoryResponseLatency = 1,
    parameter type         mem_req_t             = snitch_tcdm_pkg::mem_req_t,
    parameter type         mem_rsp_t             = snitch_tcdm_pkg::mem_rsp_t
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  mem_req_t    mem_req_i,
    output mem_rsp_t    mem_rsp_o,
    output logic        rsp_valid_o,
    output logic [31:0] rd_cnt_o,
    output logic [31:0] wr_cnt_o,
    output logic        amo_err_o
);

    localparam int StrbWidth = DataWidth / 8;

    if (MemoryResponseLatency < 1 || MemoryResponseLatency > MaxMemLatency) begin : gen_latency_check
        $error("MemoryResponseLatency must be within 1..MaxMemLatency");
    end

    logic [DataWidth-1:0]    r_mem [2**MemAddrWidth];
    logic [MemAddrWidth-1:0] w_addr;
    logic                    w_req;
    logic                    w_is_amo;
    logic                    w_is_read;
    logic                    w_amo_ok;
    logic                    w_we;
    logic [DataWidth-1:0]    w_old;
    logic [DataWidth-1:0]    w_wdata;
    logic                    r_rsp_valid;
    logic [DataWidth-1:0]    r_rsp_data;
    logic                    w_dly_valid;
    logic [DataWidth-1:0]    w_dly_data;
    logic [31:0]             r_rd_cnt;
    logic [31:0]             r_wr_cnt;
    logic                    r_amo_err;
    logic                    w_unused_user;

    assign w_req         = rst_ni & mem_req_i.q_valid;
    assign w_addr        = mem_req_i.q.addr;
    assign w_is_amo      = (mem_req_i.q.amo != AMONone);
    assign w_is_read     = !w_is_amo && !mem_req_i.q.write;
    assign w_old         = r_mem[w_addr];
    assign w_unused_user = ^mem_req_i.q.user;

    // New word: strobe merge for plain writes, ALU result for AMOs.
    always_comb begin
        w_wdata  = w_old;
        w_amo_ok = 1'b1;
        if (w_is_amo) begin
            case (mem_req_i.q.amo)
                AMOSwap: w_wdata = mem_req_i.q.data;
                AMOAdd:  w_wdata = w_old + mem_req_i.q.data;
                AMOAnd:  w_wdata = w_old & mem_req_i.q.data;
                AMOOr:   w_wdata = w_old | mem_req_i.q.data;
                AMOXor:  w_wdata = w_old ^ mem_req_i.q.data;
                default: w_amo_ok = 1'b0;
            endcase
        end else begin
            for (int i = 0; i < StrbWidth; i++) begin
                if (mem_req_i.q.strb[i]) w_wdata[8*i +: 8] = mem_req_i.q.data[8*i +: 8];
            end
        end
    end

    assign w_we = w_req & (w_is_amo ? w_amo_ok : mem_req_i.q.write);

    // NOTE: the array is deliberately not reset; its contents survive rst_ni.
    always_ff @(posedge clk_i) begin
        if (w_we) r_mem[w_addr] <= w_wdata;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rd_cnt    <= '0;
            r_wr_cnt    <= '0;
            r_amo_err   <= 1'b0;
        end else begin
            r_rsp_valid <= mem_req_i.q_valid;
            r_rsp_data  <= mem_req_i.q_valid ? w_old : '0;
            if (mem_req_i.q_valid && w_is_read)             r_rd_cnt  <= r_rd_cnt + 32'd1;
            if (mem_req_i.q_valid && !w_is_read)            r_wr_cnt  <= r_wr_cnt + 32'd1;
            if (mem_req_i.q_valid && w_is_amo && !w_amo_ok) r_amo_err <= 1'b1;
        end
    end

    snitch_tcdm_mem_delay #(
        .Depth (int'(MemoryResponseLatency) - 1),
        .Width (DataWidth)
    ) i_delay (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_valid (r_rsp_valid),
        .i_data  (r_rsp_data),
        .o_valid (w_dly_valid),
        .o_data  (w_dly_data)
    );

    always_comb begin
        mem_rsp_o        = '0;
        mem_rsp_o.p.data = w_dly_valid ? w_dly_data : '0;
    end

    assign rsp_valid_o = w_dly_valid;
    assign rd_cnt_o    = r_rd_cnt;
    assign wr_cnt_o    = r_wr_cnt;
    assign amo_err_o   = r_amo_err;

endmodule
